// File: rtl/qspi_fastread_master.sv
// rtl/qspi_fastread_master.sv - SPI mode-0 Fast Read (0x0B) initiator returning a 32-bit word
module qspi_fastread_master #(
    parameter int CLK_DIV   = 4,
    parameter int DUMMY_CYC = 8,
    parameter int CSH_CYC   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] req_addr,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        busy,
    output logic        qspi_clk,
    output logic        qspi_csn,
    output logic        qspi_di,
    input  logic        qspi_do,
    output logic        qspi_wpn,
    output logic        qspi_holdn
);
    localparam int TOTAL = 64 + DUMMY_CYC;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(TOTAL);
    localparam int CW    = $clog2(CSH_CYC + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(TOTAL - 1);
    localparam logic [BW-1:0] BIT_DATA  = BW'(32 + DUMMY_CYC);
    localparam logic [BW-1:0] BIT_CMDAD = BW'(31);
    localparam logic [CW-1:0] CSH_LOAD  = CW'(CSH_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_CSH} state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div_cnt;
    logic [BW-1:0]   r_bit_cnt;
    logic [CW-1:0]   r_csh_cnt;
    logic [31:0]     r_sr_out;
    logic [31:0]     r_sr_in;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_valid;
    logic            r_req_ready;
    logic            r_busy;
    logic            r_qspi_clk;
    logic            r_qspi_csn;
    logic            r_qspi_di;
    logic            w_rsp_clear;

    assign w_rsp_clear = !r_rsp_valid || rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_csh_cnt   <= '0;
            r_sr_out    <= '0;
            r_sr_in     <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_qspi_clk  <= 1'b0;
            r_qspi_csn  <= 1'b1;
            r_qspi_di   <= 1'b0;
        end else begin
            if (r_rsp_valid && rsp_ready)
                r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_req_ready && req_valid) begin
                        r_state     <= S_START;
                        r_sr_out    <= {8'h0B, req_addr};
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_START: begin
                    r_state    <= S_SHIFT;
                    r_qspi_csn <= 1'b0;
                    r_qspi_clk <= 1'b0;
                    r_qspi_di  <= r_sr_out[31];
                    r_div_cnt  <= '0;
                    r_bit_cnt  <= '0;
                end
                S_SHIFT: begin
                    if (r_div_cnt != DIV_LAST) begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end else begin
                        r_div_cnt <= '0;
                        if (!r_qspi_clk) begin
                            // qspi_do is captured on the edge that raises qspi_clk
                            r_qspi_clk <= 1'b1;
                            if (r_bit_cnt >= BIT_DATA)
                                r_sr_in <= {r_sr_in[30:0], qspi_do};
                        end else begin
                            r_qspi_clk <= 1'b0;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_qspi_csn  <= 1'b1;
                                r_rsp_valid <= 1'b1;
                                r_rsp_data  <= r_sr_in;
                                r_busy      <= 1'b0;
                                r_csh_cnt   <= CSH_LOAD;
                                r_state     <= S_CSH;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_sr_out  <= {r_sr_out[30:0], 1'b0};
                                r_qspi_di <= (r_bit_cnt < BIT_CMDAD) ? r_sr_out[30] : 1'b0;
                            end
                        end
                    end
                end
                S_CSH: begin
                    if (r_csh_cnt != '0)
                        r_csh_cnt <= r_csh_cnt - 1'b1;
                    // IDLE is entered with req_ready already high, one cycle before accept
                    if (r_csh_cnt <= CW'(1) && w_rsp_clear) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_data   = r_rsp_data;
    assign rsp_valid  = r_rsp_valid;
    assign busy       = r_busy;
    assign qspi_clk   = r_qspi_clk;
    assign qspi_csn   = r_qspi_csn;
    assign qspi_di    = r_qspi_di;
    assign qspi_wpn   = 1'b1;
    assign qspi_holdn = 1'b1;
endmodule

// File: tb/tb_qspi_fastread_master.sv
// tb/tb_qspi_fastread_master.sv - directed bench for qspi_fastread_master, three parameterisations
module tb_qspi_fastread_master;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0][23:0] req_addr = '0;
    logic [2:0]       req_valid = '0;
    logic [2:0]       rsp_ready = '1;
    logic [2:0]       qdo = '0;
    wire  [2:0]       req_ready, rsp_valid, busy, qclk, qcsn, qdi, qwpn, qholdn;
    wire  [2:0][31:0] rsp_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // instance 0: CLK_DIV=2 DUMMY=8, instance 1: CLK_DIV=1 DUMMY=0, instance 2: CLK_DIV=5 DUMMY=10
    for (genvar g = 0; g < 3; g++) begin : g_dut
        qspi_fastread_master #(
            .CLK_DIV  (g == 0 ? 2 : (g == 1 ? 1 : 5)),
            .DUMMY_CYC(g == 0 ? 8 : (g == 1 ? 0 : 10)),
            .CSH_CYC  (8)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req_addr  (req_addr[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .rsp_data  (rsp_data[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .busy      (busy[g]),
            .qspi_clk  (qclk[g]),
            .qspi_csn  (qcsn[g]),
            .qspi_di   (qdi[g]),
            .qspi_do   (qdo[g]),
            .qspi_wpn  (qwpn[g]),
            .qspi_holdn(qholdn[g])
        );
    end

    // Flash slave model and link monitor, evaluated on the falling clk edge
    int          ncyc = 0;
    int          rises[3] = '{0, 0, 0};
    int          low_cnt[3] = '{0, 0, 0};
    int          last_low[3] = '{0, 0, 0};
    int          last_rises[3] = '{0, 0, 0};
    int          tail_ones[3] = '{0, 0, 0};
    int          di_viol[3] = '{0, 0, 0};
    int          ck_viol[3] = '{0, 0, 0};
    int          rise_at[3] = '{0, 0, 0};
    int          gap[3] = '{0, 0, 0};
    logic [31:0] cmd_cap[3] = '{0, 0, 0};
    logic [31:0] slave_word[3] = '{0, 0, 0};
    bit          p_clk[3] = '{0, 0, 0};
    bit          p_csn[3] = '{1, 1, 1};
    bit          p_di[3] = '{0, 0, 0};

    function automatic logic slave_bit(input int i, input int k);
        int base;
        base = 32 + (i == 0 ? 8 : (i == 1 ? 0 : 10));
        if (k >= base && k < base + 32)
            return slave_word[i][31 - (k - base)];
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < 3; i++) begin
            if (qdi[i] !== p_di[i] && !(p_clk[i] && !qclk[i]) && !(p_csn[i] && !qcsn[i]))
                di_viol[i]++;
            if (qcsn[i] && qclk[i])
                ck_viol[i]++;
            if (p_csn[i] && !qcsn[i]) begin
                rises[i] = 0; low_cnt[i] = 0; cmd_cap[i] = 0; tail_ones[i] = 0;
                gap[i] = ncyc - rise_at[i];
            end
            if (!p_csn[i] && qcsn[i]) begin
                rise_at[i] = ncyc; last_low[i] = low_cnt[i]; last_rises[i] = rises[i];
            end
            if (!qcsn[i])
                low_cnt[i]++;
            if (!p_clk[i] && qclk[i]) begin
                if (rises[i] < 32) cmd_cap[i] = {cmd_cap[i][30:0], qdi[i]};
                else if (qdi[i]) tail_ones[i]++;
                rises[i]++;
            end
            if ((p_clk[i] && !qclk[i]) || (p_csn[i] && !qcsn[i]))
                qdo[i] = slave_bit(i, rises[i]);
            p_clk[i] = qclk[i]; p_csn[i] = qcsn[i]; p_di[i] = qdi[i];
        end
    end

    task automatic run_read(input int g, input logic [23:0] a, input logic [31:0] w,
                            output logic [31:0] d, output bit ok);
        int n;
        slave_word[g] = w; ok = 0; d = '0;
        for (n = 0; n < 100 && !req_ready[g]; n++) @(negedge clk);
        req_addr[g] = a; req_valid[g] = 1'b1;
        @(negedge clk);
        req_valid[g] = 1'b0;
        for (n = 0; n < 3000; n++) begin
            if (rsp_valid[g]) begin d = rsp_data[g]; ok = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++; if (qcsn[0] !== 1'b1) begin miscompares++; $display("FAIL reset_csn got %b want 1", qcsn[0]); end
        vectors++; if (qclk[0] !== 1'b0) begin miscompares++; $display("FAIL reset_clk got %b want 0", qclk[0]); end
        vectors++; if (qdi[0] !== 1'b0) begin miscompares++; $display("FAIL reset_di got %b want 0", qdi[0]); end
        vectors++; if (rsp_valid[0] !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid[0]); end
        vectors++; if (rsp_data[0] !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_data got %h want 0", rsp_data[0]); end
        vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy[0]); end
        vectors++; if (req_ready[0] !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready got %b want 0", req_ready[0]); end
        vectors++; if ({qwpn[0], qholdn[0]} !== 2'b11) begin miscompares++; $display("FAIL reset_wp_hold got %b want 11", {qwpn[0], qholdn[0]}); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL reset_ready_rise got %b want 1", req_ready[0]); end
    endtask

    task automatic test_basic();
        logic [31:0] d; bit ok;
        run_read(0, 24'h123456, 32'hA55AC33C, d, ok);
        vectors++; if (!ok || d !== 32'hA55AC33C) begin miscompares++; $display("FAIL basic_data got %h (ok=%0d) want a55ac33c", d, ok); end
        vectors++; if (cmd_cap[0] !== 32'h0B123456) begin miscompares++; $display("FAIL basic_cmd_addr got %h want 0b123456", cmd_cap[0]); end
        vectors++; if (tail_ones[0] !== 0) begin miscompares++; $display("FAIL basic_di_tail got %0d ones want 0", tail_ones[0]); end
        vectors++; if (last_rises[0] !== 72) begin miscompares++; $display("FAIL basic_rises got %0d want 72", last_rises[0]); end
        vectors++; if (last_low[0] !== 288) begin miscompares++; $display("FAIL basic_csn_low got %0d want 288", last_low[0]); end
        vectors++; if (di_viol[0] !== 0) begin miscompares++; $display("FAIL basic_di_align got %0d bad edges want 0", di_viol[0]); end
        vectors++; if (ck_viol[0] !== 0) begin miscompares++; $display("FAIL basic_clk_csn got %0d bad cycles want 0", ck_viol[0]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; bit ok; int bad;
        rsp_ready[0] = 1'b0; bad = 0;
        run_read(0, 24'h000100, 32'h0F1E2D3C, d, ok);
        for (int n = 0; n < 50; n++) begin
            if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'h0F1E2D3C || req_ready[0] !== 1'b0 || busy[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        vectors++; if (!ok || bad !== 0) begin miscompares++; $display("FAIL bp_stall got %0d bad cycles (ok=%0d) want 0", bad, ok); end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        vectors++; if (rsp_valid[0] !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop got %b want 0", rsp_valid[0]); end
        vectors++; if (req_ready[0] !== 1'b1) begin miscompares++; $display("FAIL bp_ready_rise got %b want 1", req_ready[0]); end
    endtask

    task automatic test_back_to_back();
        int n; bit tmo; logic [31:0] d;
        tmo = 0; d = '0;
        slave_word[0] = 32'h600DF00D;
        req_addr[0] = 24'h000000; req_valid[0] = 1'b1;
        for (n = 0; n < 100 && !busy[0]; n++) @(negedge clk);
        if (n >= 100) tmo = 1;
        req_addr[0] = 24'hFFFFFC;
        for (n = 0; n < 1000 && busy[0]; n++) @(negedge clk);
        if (n >= 1000) tmo = 1;
        for (n = 0; n < 100 && !busy[0]; n++) @(negedge clk);
        if (n >= 100) tmo = 1;
        req_valid[0] = 1'b0;
        for (n = 0; n < 1000 && !rsp_valid[0]; n++) @(negedge clk);
        if (n >= 1000) tmo = 1;
        d = rsp_data[0];
        @(negedge clk);
        vectors++; if (tmo) begin miscompares++; $display("FAIL b2b_timeout got timeout want completion"); end
        vectors++; if (gap[0] !== 9) begin miscompares++; $display("FAIL b2b_gap got %0d want 9", gap[0]); end
        vectors++; if (cmd_cap[0] !== 32'h0BFFFFFC) begin miscompares++; $display("FAIL b2b_addr got %h want 0bfffffc", cmd_cap[0]); end
        vectors++; if (d !== 32'h600DF00D) begin miscompares++; $display("FAIL b2b_data got %h want 600df00d", d); end
    endtask

    task automatic test_edge_align();
        logic [31:0] d; bit ok;
        run_read(1, 24'h5A5A5A, 32'h80000001, d, ok);
        vectors++; if (!ok || d !== 32'h80000001) begin miscompares++; $display("FAIL div1_data got %h (ok=%0d) want 80000001", d, ok); end
        vectors++; if (cmd_cap[1] !== 32'h0B5A5A5A) begin miscompares++; $display("FAIL div1_cmd got %h want 0b5a5a5a", cmd_cap[1]); end
        vectors++; if (last_low[1] !== 128) begin miscompares++; $display("FAIL div1_csn_low got %0d want 128", last_low[1]); end
        vectors++; if (di_viol[1] !== 0 || ck_viol[1] !== 0) begin miscompares++; $display("FAIL div1_align got %0d/%0d want 0/0", di_viol[1], ck_viol[1]); end
        run_read(2, 24'hC0FFEE, 32'h80000001, d, ok);
        vectors++; if (!ok || d !== 32'h80000001) begin miscompares++; $display("FAIL div5_data got %h (ok=%0d) want 80000001", d, ok); end
        vectors++; if (cmd_cap[2] !== 32'h0BC0FFEE) begin miscompares++; $display("FAIL div5_cmd got %h want 0bc0ffee", cmd_cap[2]); end
        vectors++; if (last_low[2] !== 740) begin miscompares++; $display("FAIL div5_csn_low got %0d want 740", last_low[2]); end
        vectors++; if (di_viol[2] !== 0 || ck_viol[2] !== 0) begin miscompares++; $display("FAIL div5_align got %0d/%0d want 0/0", di_viol[2], ck_viol[2]); end
    endtask

    task automatic test_dummy();
        logic [31:0] d; bit ok;
        run_read(1, 24'h010203, 32'h00FF00FF, d, ok);
        vectors++; if (last_rises[1] !== 64) begin miscompares++; $display("FAIL dummy0_rises got %0d want 64", last_rises[1]); end
        vectors++; if (!ok || d !== 32'h00FF00FF) begin miscompares++; $display("FAIL dummy0_data got %h (ok=%0d) want 00ff00ff", d, ok); end
        run_read(2, 24'h040506, 32'hDEADBEEF, d, ok);
        vectors++; if (last_rises[2] !== 74) begin miscompares++; $display("FAIL dummy10_rises got %0d want 74", last_rises[2]); end
        vectors++; if (!ok || d !== 32'hDEADBEEF) begin miscompares++; $display("FAIL dummy10_data got %h (ok=%0d) want deadbeef", d, ok); end
    endtask

    task automatic test_reset_mid();
        int n; logic [31:0] d; bit ok;
        slave_word[0] = 32'hFFFFFFFF;
        for (n = 0; n < 100 && !req_ready[0]; n++) @(negedge clk);
        req_addr[0] = 24'h2AAAAA; req_valid[0] = 1'b1;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (n = 0; n < 500 && rises[0] < 18; n++) @(negedge clk);
        vectors++; if (n >= 500) begin miscompares++; $display("FAIL midrst_reach got timeout want address bit 10"); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (qcsn[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_csn got %b want 1", qcsn[0]); end
        vectors++; if (qclk[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_clk got %b want 0", qclk[0]); end
        vectors++; if (rsp_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_rsp_busy got %b%b want 00", rsp_valid[0], busy[0]); end
        rst = 1'b0;
        @(negedge clk);
        run_read(0, 24'h00ABCD, 32'h13579BDF, d, ok);
        vectors++; if (!ok || d !== 32'h13579BDF) begin miscompares++; $display("FAIL midrst_data got %h (ok=%0d) want 13579bdf", d, ok); end
        vectors++; if (cmd_cap[0] !== 32'h0B00ABCD) begin miscompares++; $display("FAIL midrst_cmd got %h want 0b00abcd", cmd_cap[0]); end
        vectors++; if (last_rises[0] !== 72 || ck_viol[0] !== 0) begin miscompares++; $display("FAIL midrst_rises got %0d/%0d want 72/0", last_rises[0], ck_viol[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_edge_align();
        test_dummy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/qspi_fastread_master.md
Name: qspi_fastread_master

Overview:
- SPI-mode-0 flash initiator issuing single-lane Fast Read (0x0B) transactions: 24-bit address, 8 dummy clocks, 4-byte data burst.
- Serves as the host side of the flash simulator link, so the simulator and the SDRAM backing store can be exercised on-board and in bench loopback.
- Accepts a read request on a valid/ready handshake, generates qspi_clk/qspi_csn/qspi_di, samples qspi_do, and returns a 32-bit word on a valid/ready response channel.

Parameters:
- CLK_DIV, 4, qspi_clk half-period in clk cycles (legal range >= 1).
- DUMMY_CYC, 8, dummy qspi_clk periods between address and data.
- CSH_CYC, 8, minimum clk cycles qspi_csn stays high between transactions (legal range >= 1).

Ports:
- clk  input  1  system clock; all logic in this domain.
- rst  input  1  synchronous reset, active-high.
- req_addr  input  24  flash byte address; sampled on accept.
- req_valid  input  1  request valid.
- req_ready  output  1  high only in IDLE with no pending response.
- rsp_data  output  32  read data; first byte received in [31:24].
- rsp_valid  output  1  response valid; held until rsp_ready.
- rsp_ready  input  1  response accept.
- busy  output  1  high from request accept until qspi_csn returns high.
- qspi_clk  output  1  serial clock; idle low.
- qspi_csn  output  1  chip select, active low.
- qspi_di  output  1  master-out data, MSB first.
- qspi_do  input  1  master-in data.
- qspi_wpn  output  1  tied 1.
- qspi_holdn  output  1  tied 1.

Behaviour:
- Reset values:
  - qspi_csn=1, qspi_clk=0, qspi_di=0.
  - rsp_valid=0, rsp_data=0, busy=0, req_ready=0.
  - State is IDLE; req_ready rises the cycle after rst deasserts.
- States:
  - IDLE -> SHIFT on req_valid&&req_ready, at edge T. Latch {0x0B, req_addr}.
  - SHIFT covers 8 cmd + 24 addr + DUMMY_CYC dummy + 32 data bits. Default total is 72 bit periods.
  - SHIFT -> CSH after the last bit.
  - CSH -> IDLE when the CSH counter has expired and no response is pending.
- Bit timing: each bit period is 2*CLK_DIV clk cycles.
  - At T+1: qspi_csn=0, qspi_clk=0, qspi_di=cmd[7].
  - qspi_clk stays low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - qspi_di changes only on the edge that drives qspi_clk 1->0, or at transaction start. It is stable through each rising edge.
  - qspi_do is registered on the same clk edge that drives qspi_clk 0->1.
- Dummy and data phases:
  - During dummy and data phases qspi_di=0.
  - Data bits are shifted into a 32-bit register MSB-first.
  - Dummy-phase qspi_do samples are discarded.
- End of transaction: at the edge ending the last high phase, which is T+1+2*CLK_DIV*(64+DUMMY_CYC):
  - qspi_clk=0 and qspi_csn=1.
  - rsp_valid=1, rsp_data=shift register.
  - busy=0 and the CSH counter starts.
  - qspi_csn low time = 2*CLK_DIV*(64+DUMMY_CYC) clk cycles; with defaults this is 576.
- Response: rsp_valid/rsp_data stay stable until rsp_valid&&rsp_ready; rsp_valid clears on the next edge.
- Back-to-back transactions:
  - req_ready stays 0 until the CSH counter has expired and rsp_valid=0.
  - A new request cannot start while a response is stalled.
  - The minimum gap from qspi_csn rising to the next falling is CSH_CYC+1 cycles.
- Simultaneous events:
  - rsp_ready is honoured in any state.
  - req_valid asserted outside IDLE is ignored and held by the requester.
- Reset mid-transaction:
  - On the next edge qspi_csn=1 and qspi_clk=0.
  - The partial data is discarded and rsp_valid=0.
  - No glitch pulse occurs on qspi_clk.
- qspi_clk never toggles while qspi_csn=1.

Test Plan:
- Basic read: CLK_DIV=2, req_addr=0x123456, slave model returns 0xA5,0x5A,0xC3,0x3C.
  - qspi_di bitstream is 0x0B,0x12,0x34,0x56, then 40 zeros.
  - 72 qspi_clk rising edges; qspi_csn low for exactly 288 cycles.
  - rsp_data=0xA55AC33C.
- Response backpressure: hold rsp_ready=0 for 50 cycles after rsp_valid.
  - rsp_data remains stable and req_ready stays 0.
  - After rsp_ready=1: rsp_valid drops next edge; req_ready rises once CSH_CYC has elapsed.
- Back-to-back: req_valid held high with addresses 0x000000 then 0xFFFFFC, rsp_ready=1.
  - Second qspi_csn falling occurs exactly CSH_CYC+1 cycles after the first rising.
  - Address bits on the second transaction are all ones except the last two.
- Edge alignment: CLK_DIV=1 and CLK_DIV=5.
  - qspi_di only transitions together with qspi_clk falling or qspi_csn falling.
  - qspi_do captured at each rising edge; rsp_data matches the model for pattern 0x80000001.
- Reset mid-operation: assert rst during address bit 10.
  - Next edge: qspi_csn=1, qspi_clk=0, rsp_valid=0.
  - A subsequent request to 0x00ABCD completes correctly.
- Dummy parameter: DUMMY_CYC=0 and 10.
  - Rising edge counts are 64 and 74; data is still correctly aligned.
